// File: rtl/hex_reg_entry.sv
// Hex register entry: turns a stream of ASCII hex digits and edit keys
// into a register value, committed only on a frame boundary.
module hex_reg_entry #(
    parameter int DIGITS = 4
) (
    input  logic                           px_clk,
    input  logic                           reset_n,
    input  logic [7:0]                     char_i,
    input  logic                           char_valid_i,
    output logic                           char_ready_o,
    input  logic                           vs_i,
    output logic [4*DIGITS-1:0]            register_o,
    output logic [4*DIGITS-1:0]            edit_o,
    output logic [$clog2(DIGITS+1)-1:0]    digits_o,
    output logic                           update_o,
    output logic                           error_o
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        EDIT,
        PENDING
    } state_t;

    typedef enum logic [2:0] {
        K_DIGIT,
        K_BS,
        K_ESC,
        K_ENTER,
        K_OTHER
    } kind_t;

    state_t         state;
    kind_t          kind;
    logic [3:0]     nibble;
    logic [W-1:0]   commit;
    logic           vs_q;
    logic           frame_edge;
    logic           accept;
    logic           is_dec;
    logic           is_upper;
    logic           is_lower;

    assign is_dec   = (char_i >= 8'h30) && (char_i <= 8'h39);
    assign is_upper = (char_i >= 8'h41) && (char_i <= 8'h46);
    assign is_lower = (char_i >= 8'h61) && (char_i <= 8'h66);

    // Letters A-F / a-f share low bits 1..6, so +9 maps them to 10..15.
    always_comb begin
        kind   = K_OTHER;
        nibble = 4'h0;
        unique case (1'b1)
            is_dec: begin
                kind   = K_DIGIT;
                nibble = char_i[3:0];
            end
            is_upper, is_lower: begin
                kind   = K_DIGIT;
                nibble = char_i[3:0] + 4'd9;
            end
            (char_i == 8'h08): kind = K_BS;
            (char_i == 8'h1B): kind = K_ESC;
            (char_i == 8'h0D): kind = K_ENTER;
            default:           kind = K_OTHER;
        endcase
    end

    assign frame_edge = vs_i & ~vs_q;
    assign accept     = char_valid_i & char_ready_o;

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= EDIT;
            register_o   <= '0;
            edit_o       <= '0;
            digits_o     <= '0;
            commit       <= '0;
            vs_q         <= 1'b0;
            char_ready_o <= 1'b1;
            update_o     <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            vs_q     <= vs_i;
            update_o <= 1'b0;
            error_o  <= 1'b0;
            unique case (state)
                EDIT: begin
                    if (accept) begin
                        unique case (kind)
                            K_DIGIT: begin
                                if (digits_o < FULL) begin
                                    edit_o   <= {edit_o[W-5:0], nibble};
                                    digits_o <= digits_o + ONE;
                                end else begin
                                    error_o <= 1'b1;
                                end
                            end
                            K_BS: begin
                                if (digits_o != '0) begin
                                    edit_o   <= edit_o >> 4;
                                    digits_o <= digits_o - ONE;
                                end
                            end
                            K_ESC: begin
                                edit_o   <= '0;
                                digits_o <= '0;
                            end
                            K_ENTER: begin
                                if (digits_o != '0) begin
                                    commit       <= edit_o;
                                    state        <= PENDING;
                                    char_ready_o <= 1'b0;
                                end
                            end
                            default: error_o <= 1'b1;
                        endcase
                    end
                end
                PENDING: begin
                    // Echo stays on screen until the frame edge swaps it in.
                    if (frame_edge) begin
                        register_o   <= commit;
                        update_o     <= 1'b1;
                        edit_o       <= '0;
                        digits_o     <= '0;
                        state        <= EDIT;
                        char_ready_o <= 1'b1;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_reg_entry.sv
// Directed bench for hex_reg_entry with a queue-based scoreboard.
module tb_hex_reg_entry;

    logic        px_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        vs_i;
    logic [15:0] register_o;
    logic [15:0] edit_o;
    logic [2:0]  digits_o;
    logic        update_o;
    logic        error_o;

    hex_reg_entry #(.DIGITS(4)) dut (
        .px_clk       (px_clk),
        .reset_n      (reset_n),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .vs_i         (vs_i),
        .register_o   (register_o),
        .edit_o       (edit_o),
        .digits_o     (digits_o),
        .update_o     (update_o),
        .error_o      (error_o)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [15:0] edit;
        logic [2:0]  digits;
        logic        err;
        logic        rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] reg_q[$];
    logic [15:0] m_edit;
    int          m_digits;
    logic [15:0] m_reg;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    task automatic model_reset();
        m_edit   = 16'h0;
        m_digits = 0;
        m_reg    = 16'h0;
        reg_q.delete();
        exp_q.delete();
    endtask

    task automatic model_char(input logic [7:0] c);
        exp_t e;
        int   v;
        v     = -1;
        e.err = 1'b0;
        e.rdy = 1'b1;
        if (c >= 8'h30 && c <= 8'h39) v = int'(c) - 48;
        else if (c >= 8'h41 && c <= 8'h46) v = int'(c) - 55;
        else if (c >= 8'h61 && c <= 8'h66) v = int'(c) - 87;
        if (v >= 0) begin
            if (m_digits < 4) begin
                m_edit = (m_edit << 4) | 16'(v);
                m_digits++;
            end else begin
                e.err = 1'b1;
            end
        end else if (c == 8'h08) begin
            if (m_digits > 0) begin
                m_edit = m_edit >> 4;
                m_digits--;
            end
        end else if (c == 8'h1B) begin
            m_edit   = 16'h0;
            m_digits = 0;
        end else if (c == 8'h0D) begin
            if (m_digits > 0) begin
                reg_q.push_back(m_edit);
                e.rdy = 1'b0;
            end
        end else begin
            e.err = 1'b1;
        end
        e.edit   = m_edit;
        e.digits = 3'(m_digits);
        exp_q.push_back(e);
    endtask

    task automatic check_char(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, ".edit"},   32'(edit_o),       32'(e.edit));
        chk({tag, ".digits"}, 32'(digits_o),     32'(e.digits));
        chk({tag, ".error"},  32'(error_o),      32'(e.err));
        chk({tag, ".ready"},  32'(char_ready_o), 32'(e.rdy));
        chk({tag, ".update"}, 32'(update_o),     32'd0);
    endtask

    task automatic send(input logic [7:0] c);
        char_i       = c;
        char_valid_i = 1'b1;
        model_char(c);
        step();
        char_valid_i = 1'b0;
        check_char($sformatf("char_%02h", c));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic frame_edge(input logic expect_update);
        vs_i = 1'b0;
        step();
        vs_i = 1'b1;
        step();
        chk("frame.update", 32'(update_o), 32'(expect_update));
        if (expect_update) begin
            chk("frame.sb_nonempty", 32'(reg_q.size() != 0), 32'd1);
            if (reg_q.size() != 0) m_reg = reg_q.pop_front();
            m_edit   = 16'h0;
            m_digits = 0;
        end
        chk("frame.register", 32'(register_o),   32'(m_reg));
        chk("frame.digits",   32'(digits_o),     32'(m_digits));
        chk("frame.edit",     32'(edit_o),       32'(m_edit));
        chk("frame.ready",    32'(char_ready_o), 32'd1);
        step();
        chk("frame.update_off", 32'(update_o), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".register"}, 32'(register_o),   32'd0);
        chk({tag, ".edit"},     32'(edit_o),       32'd0);
        chk({tag, ".digits"},   32'(digits_o),     32'd0);
        chk({tag, ".ready"},    32'(char_ready_o), 32'd1);
        chk({tag, ".update"},   32'(update_o),     32'd0);
        chk({tag, ".error"},    32'(error_o),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        char_i       = 8'h00;
        char_valid_i = 1'b0;
        vs_i         = 1'b0;
        model_reset();
        step();
        step();
        check_reset_state("reset");
        reset_n = 1'b1;
        step();

        // Basic commit
        send_str("1aB3");
        send(8'h0D);
        chk("basic.pre_register", 32'(register_o), 32'h0000);
        chk("basic.pre_edit",     32'(edit_o),     32'h1AB3);
        frame_edge(1'b1);
        chk("basic.register", 32'(register_o), 32'h1AB3);

        // Overflow and invalid characters
        send_str("12345G");
        chk("ovf.edit", 32'(edit_o), 32'h1234);
        send(8'h1B);

        // Edit keys
        send_str("7F");
        send(8'h08);
        send_str("0");
        send(8'h0D);
        frame_edge(1'b1);
        chk("keys.register", 32'(register_o), 32'h0070);
        send_str("99");
        send(8'h1B);
        send(8'h7E);

        // Enter with no digits is ignored; frame edge in EDIT does nothing
        send(8'h0D);
        frame_edge(1'b0);
        chk("noenter.register", 32'(register_o), 32'h0070);

        // Enter coincident with a frame edge, then vs held high
        send_str("2F");
        vs_i = 1'b0;
        step();
        vs_i         = 1'b1;
        char_i       = 8'h0D;
        char_valid_i = 1'b1;
        model_char(8'h0D);
        step();
        char_valid_i = 1'b0;
        check_char("edge_enter");
        chk("edge_enter.register", 32'(register_o), 32'h0070);
        step();
        step();
        chk("edge_hold.update",   32'(update_o),     32'd0);
        chk("edge_hold.register", 32'(register_o),   32'h0070);
        chk("edge_hold.ready",    32'(char_ready_o), 32'd0);
        frame_edge(1'b1);
        chk("partial.register", 32'(register_o), 32'h002F);

        // Backpressure in PENDING, then reset mid-PENDING
        send_str("5");
        send(8'h0D);
        char_i       = 8'h35;
        char_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.edit",   32'(edit_o),       32'h0005);
            chk("bp.digits", 32'(digits_o),     32'd1);
            chk("bp.ready",  32'(char_ready_o), 32'd0);
            chk("bp.error",  32'(error_o),      32'd0);
        end
        char_valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midreset");
        step();
        reset_n = 1'b1;
        step();
        frame_edge(1'b0);
        chk("midreset.register", 32'(register_o), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
